tlc_input_conditioner: RTL and testbench

- Upstream front end of the TrafficLightController.
- Turns raw asynchronous push-button and switch inputs into the clean, clock-domain signals the controller consumes: the debounced vehicle Sensor level, a latched WalkRequest that holds until the controller acknowledges it, and a single-cycle Reprogram pulse with captured Selector/Time_Value.
- Runs on the controller's 100 kHz clk (10 us period).

---
 rtl/tlc_input_conditioner_if.sv | 25 ++
 rtl/tlc_input_conditioner.sv | 134 +++++++++++++
 tb/tb_tlc_input_conditioner.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tlc_input_conditioner_if.sv
// Raw-input / conditioned-output bundle between the button front end and the controller.
// master = the conditioner, slave = the environment and controller side.
interface tlc_input_conditioner_if;
  logic       Sensor_raw;
  logic       WalkRequest_raw;
  logic       Reprogram_raw;
  logic [1:0] Selector_raw;
  logic [3:0] Time_Value_raw;
  logic       walk_clear;
  logic       Sensor;
  logic       WalkRequest;
  logic       Reprogram;
  logic [1:0] Selector;
  logic [3:0] Time_Value;

  modport master (
    input  Sensor_raw, WalkRequest_raw, Reprogram_raw, Selector_raw, Time_Value_raw, walk_clear,
    output Sensor, WalkRequest, Reprogram, Selector, Time_Value
  );

  modport slave (
    output Sensor_raw, WalkRequest_raw, Reprogram_raw, Selector_raw, Time_Value_raw, walk_clear,
    input  Sensor, WalkRequest, Reprogram, Selector, Time_Value
  );
endinterface

// File: rtl/tlc_input_conditioner.sv
// Synchronizes, debounces and edge-conditions the traffic-light raw inputs.
// Optional macro SENSOR_HOLD_EN stretches Sensor by HOLD_CYCLES after the debounced level drops.
module tlc_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2
`ifdef SENSOR_HOLD_EN
  , parameter int HOLD_CYCLES = 100000
`endif
) (
  input logic                     clk,
  input logic                     Reset,
  tlc_input_conditioner_if.master bus
);
  localparam int         NCH      = 3;
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 = sensor, 1 = walk, 2 = reprogram.
  logic [NCH-1:0] w_raw;
  logic [5:0]     w_cfg_raw;
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;
  logic [5:0]     r_cfg_sync1;
  logic [5:0]     r_cfg_sync2;
  logic [NCH-1:0] w_deb;

  assign w_raw     = {bus.Reprogram_raw, bus.WalkRequest_raw, bus.Sensor_raw};
  assign w_cfg_raw = {bus.Selector_raw, bus.Time_Value_raw};

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_cfg_sync1 <= '0;
      r_cfg_sync2 <= '0;
    end else begin
      r_sync1     <= w_raw;
      r_sync2     <= r_sync1;
      r_cfg_sync1 <= w_cfg_raw;
      r_cfg_sync2 <= r_cfg_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_deb
      logic [7:0] r_cnt;
      logic       r_deb;

      // Any return to the current level before the count completes discards the glitch.
      always_ff @(posedge clk) begin
        if (Reset) begin
          r_cnt <= '0;
          r_deb <= 1'b0;
        end else if (r_sync2[gi] != r_deb) begin
          if (r_cnt == DEB_LAST) begin
            r_deb <= r_sync2[gi];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_deb[gi] = r_deb;
    end
  endgenerate

  logic       r_walk_deb_q;
  logic       r_repr_deb_q;
  logic       r_walk_req;
  logic       r_reprogram;
  logic [1:0] r_selector;
  logic [3:0] r_time_value;
  logic       w_walk_rise;
  logic       w_repr_rise;

  assign w_walk_rise = w_deb[1] & ~r_walk_deb_q;
  assign w_repr_rise = w_deb[2] & ~r_repr_deb_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_walk_deb_q <= 1'b0;
      r_repr_deb_q <= 1'b0;
      r_walk_req   <= 1'b0;
      r_reprogram  <= 1'b0;
      r_selector   <= 2'b00;
      r_time_value <= 4'h0;
    end else begin
      r_walk_deb_q <= w_deb[1];
      r_repr_deb_q <= w_deb[2];
      // A new press beats a simultaneous acknowledge so no request is lost.
      if (w_walk_rise) begin
        r_walk_req <= 1'b1;
      end else if (bus.walk_clear) begin
        r_walk_req <= 1'b0;
      end
      r_reprogram <= w_repr_rise;
      if (w_repr_rise) begin
        r_selector   <= r_cfg_sync2[5:4];
        r_time_value <= r_cfg_sync2[3:0];
      end
    end
  end

`ifdef SENSOR_HOLD_EN
  localparam logic [16:0] HOLD_LIM = 17'(HOLD_CYCLES);

  logic [16:0] r_hold_cnt;
  logic        r_hold_seen;

  // Counts cycles since the debounced level dropped; saturates so it never wraps back into the window.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_hold_cnt  <= '0;
      r_hold_seen <= 1'b0;
    end else if (w_deb[0]) begin
      r_hold_cnt  <= '0;
      r_hold_seen <= 1'b1;
    end else if (r_hold_cnt != 17'h1FFFF) begin
      r_hold_cnt <= r_hold_cnt + 17'd1;
    end
  end

  assign bus.Sensor = w_deb[0] | (r_hold_seen & (r_hold_cnt < HOLD_LIM));
`else
  assign bus.Sensor = w_deb[0];
`endif

  assign bus.WalkRequest = r_walk_req;
  assign bus.Reprogram   = r_reprogram;
  assign bus.Selector    = r_selector;
  assign bus.Time_Value  = r_time_value;
endmodule

// File: tb/tb_tlc_input_conditioner.sv
// Cycle table plus hand sequences for tlc_input_conditioner (DEBOUNCE_CYCLES=2).
// Build with SENSOR_HOLD_EN to exercise the sensor stretch with HOLD_CYCLES=5.
module tb_tlc_input_conditioner;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  tlc_input_conditioner_if bus();

`ifdef SENSOR_HOLD_EN
  tlc_input_conditioner #(.DEBOUNCE_CYCLES(2), .HOLD_CYCLES(5)) dut (.clk(clk), .Reset(Reset), .bus(bus));
`else
  tlc_input_conditioner #(.DEBOUNCE_CYCLES(2)) dut (.clk(clk), .Reset(Reset), .bus(bus));
`endif

  typedef struct {
    logic       rst, s, w, r, wc;
    logic [1:0] sel;
    logic [3:0] tv;
    logic       es, ew, er;
    logic [1:0] esel;
    logic [3:0] etv;
  } vec_t;

  typedef struct {
    logic       s, w, r;
    logic [1:0] sel;
    logic [3:0] tv;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] tv;
  } cap_t;

  vec_t vecs[$];
  exp_t sb[$];
  cap_t cap_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic       c_rst, c_s, c_w, c_r, c_wc;
  logic [1:0] c_sel;
  logic [3:0] c_tv;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic es, input logic ew, input logic er,
                     input logic [1:0] esel, input logic [3:0] etv);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = c_rst; v.s = c_s; v.w = c_w; v.r = c_r; v.wc = c_wc;
      v.sel = c_sel; v.tv = c_tv;
      v.es = es; v.ew = ew; v.er = er; v.esel = esel; v.etv = etv;
      vecs.push_back(v);
    end
  endtask

  task automatic drive(input vec_t v);
    Reset               = v.rst;
    bus.Sensor_raw      = v.s;
    bus.WalkRequest_raw = v.w;
    bus.Reprogram_raw   = v.r;
    bus.walk_clear      = v.wc;
    bus.Selector_raw    = v.sel;
    bus.Time_Value_raw  = v.tv;
  endtask

  initial begin
    exp_t e;
    cap_t cp;
    int   n;
    int   extra;
    logic seen;

    c_rst = 1'b1; c_s = 1'b0; c_w = 1'b0; c_r = 1'b0; c_wc = 1'b0; c_sel = 2'b00; c_tv = 4'h0;
    // reset held 3 cycles, then sensor press: high on the 4th sampling edge
    add(3, 0, 0, 0, 2'b00, 4'h0);
    c_rst = 1'b0; add(1, 0, 0, 0, 2'b00, 4'h0);
    c_s = 1'b1; add(3, 0, 0, 0, 2'b00, 4'h0); add(2, 1, 0, 0, 2'b00, 4'h0);
    c_s = 1'b0; add(3, 1, 0, 0, 2'b00, 4'h0); add(2, 0, 0, 0, 2'b00, 4'h0);
    // 3-cycle pulse passes for 3 cycles, 1-cycle pulse is rejected
    c_s = 1'b1; add(3, 0, 0, 0, 2'b00, 4'h0);
    c_s = 1'b0; add(3, 1, 0, 0, 2'b00, 4'h0); add(3, 0, 0, 0, 2'b00, 4'h0);
    c_s = 1'b1; add(1, 0, 0, 0, 2'b00, 4'h0);
    c_s = 1'b0; add(5, 0, 0, 0, 2'b00, 4'h0);
    // walk: set after debounce + edge register, sticky past release, cleared by ack
    c_w = 1'b1; add(4, 0, 0, 0, 2'b00, 4'h0); add(1, 0, 1, 0, 2'b00, 4'h0);
    c_w = 1'b0; add(5, 0, 1, 0, 2'b00, 4'h0);
    c_wc = 1'b1; add(1, 0, 0, 0, 2'b00, 4'h0);
    c_wc = 1'b0; add(1, 0, 0, 0, 2'b00, 4'h0);
    // new press with ack in the rise cycle: set wins; then clear while held does not re-set
    c_w = 1'b1; add(4, 0, 0, 0, 2'b00, 4'h0);
    c_wc = 1'b1; add(1, 0, 1, 0, 2'b00, 4'h0);
    c_wc = 1'b0; add(1, 0, 1, 0, 2'b00, 4'h0);
    c_wc = 1'b1; add(1, 0, 0, 0, 2'b00, 4'h0);
    c_wc = 1'b0; add(1, 0, 0, 0, 2'b00, 4'h0);
    c_w = 1'b0; add(5, 0, 0, 0, 2'b00, 4'h0);
    // reprogram: single strobe with captured switches, later switch changes ignored
    c_sel = 2'b10; c_tv = 4'h9; add(2, 0, 0, 0, 2'b00, 4'h0);
    c_r = 1'b1; add(4, 0, 0, 0, 2'b00, 4'h0); add(1, 0, 0, 1, 2'b10, 4'h9);
    c_r = 1'b0; add(1, 0, 0, 0, 2'b10, 4'h9);
    c_tv = 4'h3; add(5, 0, 0, 0, 2'b10, 4'h9);
    // reset mid-debounce with walk held: all zero, then one fresh set
    c_w = 1'b1; add(1, 0, 0, 0, 2'b10, 4'h9);
    c_rst = 1'b1; add(2, 0, 0, 0, 2'b00, 4'h0);
    c_rst = 1'b0; add(4, 0, 0, 0, 2'b00, 4'h0); add(5, 0, 1, 0, 2'b00, 4'h0);

    Reset = 1'b1;
    drive(vecs[0]);
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      e.s = vecs[i].es; e.w = vecs[i].ew; e.r = vecs[i].er; e.sel = vecs[i].esel; e.tv = vecs[i].etv;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
`ifndef SENSOR_HOLD_EN
      chk($sformatf("row%0d_Sensor", i), int'(bus.Sensor), int'(e.s));
`endif
      chk($sformatf("row%0d_WalkRequest", i), int'(bus.WalkRequest), int'(e.w));
      chk($sformatf("row%0d_Reprogram", i), int'(bus.Reprogram), int'(e.r));
      chk($sformatf("row%0d_Selector", i), int'(bus.Selector), int'(e.sel));
      chk($sformatf("row%0d_Time_Value", i), int'(bus.Time_Value), int'(e.tv));
    end

    // hand sequence: strobe latency, captured values and single-fire while held
    bus.WalkRequest_raw = 1'b0;
    bus.Selector_raw    = 2'b01;
    bus.Time_Value_raw  = 4'h5;
    repeat (3) @(negedge clk);
    cp.sel = 2'b01; cp.tv = 4'h5;
    cap_q.push_back(cp);
    bus.Reprogram_raw = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (bus.Reprogram) seen = 1'b1;
    end
    chk("strobe_latency", seen ? n : 99, 5);
    if (seen && cap_q.size() > 0) begin
      cp = cap_q.pop_front();
      chk("strobe_Selector", int'(bus.Selector), int'(cp.sel));
      chk("strobe_Time_Value", int'(bus.Time_Value), int'(cp.tv));
    end
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) bus.Reprogram_raw = 1'b0;
      @(posedge clk); @(negedge clk);
      if (bus.Reprogram) extra++;
    end
    chk("strobe_once", extra, 0);
    chk("scoreboard_drained", sb.size() + cap_q.size(), 0);

`ifdef SENSOR_HOLD_EN
    // stretch: single 3-cycle pulse, then a second pulse inside the hold window
    for (int t = 0; t < 2; t++) begin
      int first, last, cnt;
      first = -1; last = -1; cnt = 0;
      for (int c = 0; c < 30; c++) begin
        bus.Sensor_raw = (c < 3) || (t == 1 && c >= 6 && c < 9);
        @(posedge clk); @(negedge clk);
        if (bus.Sensor) begin
          cnt++;
          if (first < 0) first = c;
          last = c;
        end
      end
      chk($sformatf("hold%0d_first", t), first, 3);
      chk($sformatf("hold%0d_cycles", t), cnt, (t == 1) ? 14 : 8);
      chk($sformatf("hold%0d_contiguous", t), last - first + 1, cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
